// File: rtl/tri_setup_seq_pkg.sv
// Shared widths, FSM encoding and edge-endpoint helper for the triangle setup sequencer.
package tri_setup_seq_pkg;

    localparam int COORD_W = 10;
    localparam int COEF_W  = 18;
    localparam int AREA_W  = 20;
    localparam int CNT_W   = 16;
    localparam int NUM_EDGES = 3;

    typedef logic [COORD_W-1:0]        coord_t;
    typedef logic signed [COEF_W-1:0]  coef_t;
    typedef logic signed [AREA_W-1:0]  area_t;
    typedef logic [CNT_W-1:0]          cnt_t;
    typedef logic [1:0]                edge_idx_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        GAP   = 3'd2,
        WAIT  = 3'd3,
        SUM   = 3'd4,
        OUT   = 3'd5
    } state_t;

    typedef struct packed {
        coord_t x1;
        coord_t y1;
        coord_t x2;
        coord_t y2;
    } edge_pts_t;

    // Edge k runs v0->v1, v1->v2, v2->v0 so all three share one winding.
    function automatic edge_pts_t edge_endpoints(
        input edge_idx_t k,
        input coord_t    x0,
        input coord_t    y0,
        input coord_t    x1,
        input coord_t    y1,
        input coord_t    x2,
        input coord_t    y2
    );
        edge_pts_t pts;
        case (k)
            2'd0:    pts = {x0, y0, x1, y1};
            2'd1:    pts = {x1, y1, x2, y2};
            default: pts = {x2, y2, x0, y0};
        endcase
        return pts;
    endfunction

endpackage

// File: rtl/tri_setup_seq_if.sv
// Triangle input, edge-engine and coefficient-output signals of the setup sequencer.
interface tri_setup_seq_if;
    import tri_setup_seq_pkg::*;

    logic   cull_en;
    logic   tri_valid;
    logic   tri_ready;
    coord_t x0;
    coord_t y0;
    coord_t x1;
    coord_t y1;
    coord_t x2;
    coord_t y2;

    logic   ee_trigger;
    coord_t ee_x1;
    coord_t ee_y1;
    coord_t ee_x2;
    coord_t ee_y2;
    logic   ee_valid;
    coef_t  ee_a;
    coef_t  ee_b;
    coef_t  ee_c;

    logic   out_valid;
    logic   out_ready;
    coef_t  a0;
    coef_t  b0;
    coef_t  c0;
    coef_t  a1;
    coef_t  b1;
    coef_t  c1;
    coef_t  a2;
    coef_t  b2;
    coef_t  c2;
    area_t  area2;
    cnt_t   cull_count;

    // The sequencer side.
    modport slave (
        input  cull_en, tri_valid, x0, y0, x1, y1, x2, y2,
        input  ee_valid, ee_a, ee_b, ee_c,
        input  out_ready,
        output tri_ready,
        output ee_trigger, ee_x1, ee_y1, ee_x2, ee_y2,
        output out_valid, a0, b0, c0, a1, b1, c1, a2, b2, c2, area2, cull_count
    );

    // The surrounding pipeline / engine side.
    modport master (
        output cull_en, tri_valid, x0, y0, x1, y1, x2, y2,
        output ee_valid, ee_a, ee_b, ee_c,
        output out_ready,
        input  tri_ready,
        input  ee_trigger, ee_x1, ee_y1, ee_x2, ee_y2,
        input  out_valid, a0, b0, c0, a1, b1, c1, a2, b2, c2, area2, cull_count
    );

endinterface

// File: rtl/tri_setup_seq_area_sum.sv
// Doubled signed area from the three edge constants, plus the cull decision.
module tri_setup_seq_area_sum
    import tri_setup_seq_pkg::*;
(
    input  coef_t c [NUM_EDGES],
    input  logic  cull_en,
    output area_t area2,
    output logic  cull
);

    area_t c_ext [NUM_EDGES];

    // Two guard bits are enough: three 18-bit terms cannot overflow 20 bits.
    generate
        for (genvar gi = 0; gi < NUM_EDGES; gi++) begin : g_ext
            assign c_ext[gi] = {{(AREA_W-COEF_W){c[gi][COEF_W-1]}}, c[gi]};
        end
    endgenerate

    assign area2 = c_ext[0] + c_ext[1] + c_ext[2];
    assign cull  = cull_en && (area2[AREA_W-1] || (area2 == '0));

endmodule

// File: rtl/tri_setup_seq.sv
// Triangle setup sequencer: drives a shared edge-equation engine once per edge,
// sums the edge constants into the doubled area and optionally culls.
module tri_setup_seq
    import tri_setup_seq_pkg::*;
(
    input  logic            clock,
    input  logic            reset_n,
    tri_setup_seq_if.slave  bus
);

    state_t    state_reg;
    edge_idx_t k_reg;
    edge_idx_t k_next;
    coord_t    vx_reg [NUM_EDGES];
    coord_t    vy_reg [NUM_EDGES];
    edge_pts_t ee_pt_reg;
    edge_pts_t ee_pt_next;
    logic      ee_trigger_reg;
    logic      tri_ready_reg;
    logic      out_valid_reg;
    coef_t     coef_a_reg [NUM_EDGES];
    coef_t     coef_b_reg [NUM_EDGES];
    coef_t     coef_c_reg [NUM_EDGES];
    area_t     area2_reg;
    cnt_t      cull_count_reg;

    area_t     sum_area2;
    logic      sum_cull;
    logic      accept;

    tri_setup_seq_area_sum u_area_sum (
        .c       (coef_c_reg),
        .cull_en (bus.cull_en),
        .area2   (sum_area2),
        .cull    (sum_cull)
    );

    assign accept = tri_ready_reg && bus.tri_valid;

    always_comb begin
        k_next     = k_reg + 2'd1;
        ee_pt_next = edge_endpoints(k_next, vx_reg[0], vy_reg[0],
                                    vx_reg[1], vy_reg[1], vx_reg[2], vy_reg[2]);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            k_reg          <= '0;
            ee_pt_reg      <= '0;
            ee_trigger_reg <= 1'b0;
            tri_ready_reg  <= 1'b0;
            out_valid_reg  <= 1'b0;
            area2_reg      <= '0;
            cull_count_reg <= '0;
            for (int i = 0; i < NUM_EDGES; i++) begin
                vx_reg[i]     <= '0;
                vy_reg[i]     <= '0;
                coef_a_reg[i] <= '0;
                coef_b_reg[i] <= '0;
                coef_c_reg[i] <= '0;
            end
        end else begin
            ee_trigger_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        vx_reg[0]     <= bus.x0;
                        vy_reg[0]     <= bus.y0;
                        vx_reg[1]     <= bus.x1;
                        vy_reg[1]     <= bus.y1;
                        vx_reg[2]     <= bus.x2;
                        vy_reg[2]     <= bus.y2;
                        k_reg         <= '0;
                        ee_pt_reg     <= edge_endpoints(2'd0, bus.x0, bus.y0,
                                                        bus.x1, bus.y1, bus.x2, bus.y2);
                        tri_ready_reg <= 1'b0;
                        state_reg     <= ISSUE;
                    end else begin
                        tri_ready_reg <= 1'b1;
                    end
                end
                ISSUE: begin
                    // The engine has no reset, so never trigger it until it reports idle.
                    if (bus.ee_valid) begin
                        ee_trigger_reg <= 1'b1;
                        state_reg      <= GAP;
                    end
                end
                GAP: begin
                    // ee_valid is still the stale idle level here; it drops next cycle.
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (bus.ee_valid) begin
                        coef_a_reg[k_reg] <= bus.ee_a;
                        coef_b_reg[k_reg] <= bus.ee_b;
                        coef_c_reg[k_reg] <= bus.ee_c;
                        if (k_reg == 2'd2) begin
                            state_reg <= SUM;
                        end else begin
                            k_reg     <= k_next;
                            ee_pt_reg <= ee_pt_next;
                            state_reg <= ISSUE;
                        end
                    end
                end
                SUM: begin
                    area2_reg <= sum_area2;
                    if (sum_cull) begin
                        if (cull_count_reg != '1) begin
                            cull_count_reg <= cull_count_reg + 1'b1;
                        end
                        tri_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end else begin
                        out_valid_reg <= 1'b1;
                        state_reg     <= OUT;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        tri_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.tri_ready  = tri_ready_reg;
    assign bus.ee_trigger = ee_trigger_reg;
    assign bus.ee_x1      = ee_pt_reg.x1;
    assign bus.ee_y1      = ee_pt_reg.y1;
    assign bus.ee_x2      = ee_pt_reg.x2;
    assign bus.ee_y2      = ee_pt_reg.y2;
    assign bus.out_valid  = out_valid_reg;
    assign bus.a0         = coef_a_reg[0];
    assign bus.b0         = coef_b_reg[0];
    assign bus.c0         = coef_c_reg[0];
    assign bus.a1         = coef_a_reg[1];
    assign bus.b1         = coef_b_reg[1];
    assign bus.c1         = coef_c_reg[1];
    assign bus.a2         = coef_a_reg[2];
    assign bus.b2         = coef_b_reg[2];
    assign bus.c2         = coef_c_reg[2];
    assign bus.area2      = area2_reg;
    assign bus.cull_count = cull_count_reg;

endmodule

// File: tb/tb_tri_setup_seq.sv
// Bench for tri_setup_seq: behavioural edge engine, table vectors, corner sequences, random triangles.
module tb_tri_setup_seq;
    import tri_setup_seq_pkg::*;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    tri_setup_seq_if bus ();

    tri_setup_seq dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural edge engine: valid drops after a trigger, returns 4 cycles after it.
    logic eng_valid_i = 1'b1;
    logic eng_hold    = 1'b0;
    int   eng_busy    = 0;
    int   trig_count  = 0;

    assign bus.ee_valid = eng_valid_i && !eng_hold;

    always @(posedge clock) begin
        if (bus.ee_trigger) begin
            int px, py, qx, qy;
            trig_count++;
            px = int'(bus.ee_x1);
            py = int'(bus.ee_y1);
            qx = int'(bus.ee_x2);
            qy = int'(bus.ee_y2);
            bus.ee_a    <= COEF_W'(py - qy);
            bus.ee_b    <= COEF_W'(qx - px);
            bus.ee_c    <= COEF_W'(px * qy - qx * py);
            eng_valid_i <= 1'b0;
            eng_busy    <= 3;
        end else if (eng_busy > 0) begin
            eng_busy <= eng_busy - 1;
            if (eng_busy == 1) eng_valid_i <= 1'b1;
        end
    end

    typedef struct {
        int v[6];
        bit ce;
        bit exp_cull;
        int exp_area;
        int exp_co[9];
    } vec_t;

    vec_t tbl[4];
    int   exp_cull_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: edge k joins vertex k to vertex (k+1)%3; area2 is the sum of the c terms.
    function automatic void ref_tri(input int v[6], output int co[9], output int ar);
        ar = 0;
        for (int k = 0; k < 3; k++) begin
            int px, py, qx, qy;
            px = v[2*k];
            py = v[2*k+1];
            qx = v[2*((k+1)%3)];
            qy = v[2*((k+1)%3)+1];
            co[3*k]   = py - qy;
            co[3*k+1] = qx - px;
            co[3*k+2] = px * qy - qx * py;
            ar += co[3*k+2];
        end
    endfunction

    task automatic accept_tri(input int v[6], input bit ce);
        int n = 0;
        bus.cull_en = ce;
        while (!bus.tri_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!bus.tri_ready) chk("accept_timeout", bus.tri_ready, 1);
        bus.x0 = COORD_W'(v[0]);
        bus.y0 = COORD_W'(v[1]);
        bus.x1 = COORD_W'(v[2]);
        bus.y1 = COORD_W'(v[3]);
        bus.x2 = COORD_W'(v[4]);
        bus.y2 = COORD_W'(v[5]);
        bus.tri_valid = 1'b1;
        @(negedge clock);
        bus.tri_valid = 1'b0;
    endtask

    task automatic wait_result(input int ready_delay, output bit got_out, output int lat,
                               output int co[9], output int ar);
        int n = 0;
        int tbase;
        got_out = 1'b0;
        lat = 1;
        for (int i = 0; i < 9; i++) co[i] = 0;
        while (n < 200) begin
            if (bus.out_valid) begin
                got_out = 1'b1;
                break;
            end
            if (bus.tri_ready) break;
            @(negedge clock);
            lat++;
            n++;
        end
        if (!bus.out_valid && !bus.tri_ready) chk("result_timeout", bus.tri_ready | bus.out_valid, 1);
        ar = int'(bus.area2);
        if (got_out) begin
            co = '{int'(bus.a0), int'(bus.b0), int'(bus.c0), int'(bus.a1), int'(bus.b1),
                   int'(bus.c1), int'(bus.a2), int'(bus.b2), int'(bus.c2)};
            tbase = trig_count;
            for (int i = 0; i < ready_delay; i++) begin
                @(negedge clock);
                chk("hold_out_valid", bus.out_valid, 1);
                chk("hold_area2", bus.area2, ar);
                chk("hold_a0", bus.a0, co[0]);
                chk("hold_c2", bus.c2, co[8]);
                chk("hold_tri_ready", bus.tri_ready, 0);
                chk("hold_no_trigger", trig_count, tbase);
            end
            bus.out_ready = 1'b1;
            @(negedge clock);
            bus.out_ready = 1'b0;
            chk("out_valid_drop", bus.out_valid, 0);
        end
    endtask

    task automatic check_tri(input string tag, input int v[6], input bit ce, input int ready_delay,
                             input bit exp_cull, input int exp_area, input int exp_co[9]);
        bit got_out;
        int lat, ar;
        int co[9];
        int tb0;
        tb0 = trig_count;
        accept_tri(v, ce);
        wait_result(ready_delay, got_out, lat, co, ar);
        if (exp_cull) exp_cull_cnt++;
        chk({tag, "_out_seen"}, got_out, !exp_cull);
        chk({tag, "_area2"}, ar, exp_area);
        chk({tag, "_cull_count"}, bus.cull_count, exp_cull_cnt);
        chk({tag, "_triggers"}, trig_count - tb0, 3);
        chk({tag, "_tri_ready_back"}, bus.tri_ready, 1);
        if (!exp_cull) begin
            chk({tag, "_latency_le20"}, lat <= 20, 1);
            for (int i = 0; i < 9; i++) chk($sformatf("%s_coef%0d", tag, i), co[i], exp_co[i]);
        end
        $display("%s: v=(%0d,%0d)(%0d,%0d)(%0d,%0d) ce=%0d out=%0d area2=%0d exp=%0d lat=%0d",
                 tag, v[0], v[1], v[2], v[3], v[4], v[5], ce, got_out, ar, exp_area, lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int co[9];
        int ar, n, tb0, saw;
        int v[6];
        bit got_out;
        int lat;

        reset_n = 1'b0;
        bus.cull_en = 1'b0;
        bus.tri_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0; bus.x2 = '0; bus.y2 = '0;
        bus.ee_a = '0; bus.ee_b = '0; bus.ee_c = '0;

        tbl[0].v = '{249, 116, 347, 247, 313, 267};
        tbl[0].ce = 1'b0; tbl[0].exp_cull = 1'b0; tbl[0].exp_area = 6414;
        tbl[0].exp_co = '{-131, 98, 21251, -20, -34, 15338, 151, -64, -30175};
        tbl[1].v = '{249, 116, 313, 267, 347, 247};
        tbl[1].ce = 1'b1; tbl[1].exp_cull = 1'b1; tbl[1].exp_area = -6414;
        tbl[1].exp_co = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2].v = '{0, 0, 10, 10, 20, 20};
        tbl[2].ce = 1'b1; tbl[2].exp_cull = 1'b1; tbl[2].exp_area = 0;
        tbl[2].exp_co = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3].v = '{0, 0, 10, 10, 20, 20};
        tbl[3].ce = 1'b0; tbl[3].exp_cull = 1'b0; tbl[3].exp_area = 0;
        tbl[3].exp_co = '{-10, 10, 0, -10, 10, 0, 20, -20, 0};

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_tri_ready", bus.tri_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_ee_trigger", bus.ee_trigger, 0);
        chk("rst_cull_count", bus.cull_count, 0);
        chk("rst_area2", bus.area2, 0);
        chk("rst_a0", bus.a0, 0);
        chk("rst_c2", bus.c2, 0);
        reset_n = 1'b1;
        @(negedge clock);
        $display("reset: released");

        // Directed table
        for (int t = 0; t < 4; t++) begin
            check_tri($sformatf("tbl%0d", t), tbl[t].v, tbl[t].ce, 0,
                      tbl[t].exp_cull, tbl[t].exp_area, tbl[t].exp_co);
        end

        // Output back-pressure: out_ready low for 10 cycles
        check_tri("backpressure", tbl[0].v, 1'b0, 10, 1'b0, 6414, tbl[0].exp_co);

        // Engine held not-ready for 5 cycles ahead of edge 1
        v = '{100, 50, 30, 200, 220, 180};
        ref_tri(v, co, ar);
        tb0 = trig_count;
        accept_tri(v, 1'b0);
        n = 0;
        while (trig_count != tb0 + 1 && n < 50) begin @(negedge clock); n++; end
        n = 0;
        while (!eng_valid_i && n < 50) begin @(negedge clock); n++; end
        chk("stall_engine_ready", eng_valid_i, 1);
        eng_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("stall_no_trigger", trig_count, tb0 + 1);
            chk("stall_ee_trigger", bus.ee_trigger, 0);
        end
        eng_hold = 1'b0;
        begin
            int got_co[9];
            int got_ar;
            wait_result(0, got_out, lat, got_co, got_ar);
            chk("stall_out_seen", got_out, 1);
            chk("stall_triggers", trig_count - tb0, 3);
            chk("stall_area2", got_ar, ar);
            for (int i = 0; i < 9; i++) chk($sformatf("stall_coef%0d", i), got_co[i], co[i]);
            $display("stall: area2=%0d exp=%0d triggers=%0d", got_ar, ar, trig_count - tb0);
        end

        // Reset during WAIT of edge 1
        tb0 = trig_count;
        accept_tri(tbl[0].v, 1'b0);
        n = 0;
        while (trig_count != tb0 + 2 && n < 50) begin @(negedge clock); n++; end
        chk("abort_reached_edge1", trig_count - tb0, 2);
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        exp_cull_cnt = 0;
        saw = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (bus.out_valid) saw++;
        end
        chk("abort_no_out_valid", saw, 0);
        chk("abort_tri_ready", bus.tri_ready, 1);
        chk("abort_cull_count", bus.cull_count, 0);
        chk("abort_a0_cleared", bus.a0, 0);
        $display("abort: out_valid cycles=%0d", saw);
        check_tri("after_abort", tbl[0].v, 1'b0, 0, 1'b0, 6414, tbl[0].exp_co);

        // Random triangles against the reference
        for (int t = 0; t < 20; t++) begin
            bit ce;
            for (int i = 0; i < 6; i++) v[i] = int'($urandom_range(0, 255));
            ce = 1'($urandom_range(0, 1));
            ref_tri(v, co, ar);
            check_tri($sformatf("rand%0d", t), v, ce, int'($urandom_range(0, 3)),
                      ce && (ar <= 0), ar, co);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
